// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: button debounce, operand/op registers, one-at-a-time unit sequencing.
// Optional WAIT watchdog enabled by defining CALC_TIMEOUT_EN.

module calc_btn_debounce #(
  parameter logic [15:0] CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
);
  logic s1, s2, level, armed;
  logic [15:0] cnt;
  logic accept;

  assign accept = (s2 != level) && (cnt == CYCLES - 16'd1);

  // Synchroniser resets high so a button held through reset never arms until seen released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      armed <= armed | ~s2;
      pulse <= accept & s2 & armed;
      if (s2 == level) cnt <= '0;
      else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else cnt <= cnt + 16'd1;
    end
  end
endmodule

module calc_op_sequencer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  TIMEOUT_CYCLES  = 8'd255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] sw,
  input  logic [2:0] btn,
  output logic [2:0] op_sel,
  output logic [3:0] operand_a,
  output logic [3:0] operand_b,
  output logic [4:0] unit_start,
  input  logic [4:0] unit_done,
  input  logic [7:0] sum_in,
  input  logic [7:0] diff_in,
  input  logic [7:0] quot_in,
  input  logic [7:0] rem_in,
  input  logic [7:0] prod_in,
  input  logic [7:0] sqrt_in,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic       err_divzero,
  output logic       err_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LATCH} state_t;
  state_t state, state_nx, phase;

  logic [2:0] ev;
  logic       ev_adv, ev_load, ev_exec;
  logic [4:0] owner_mask;
  logic       owner_done, divz, timed_out;
  logic [7:0] sel_result;

  for (genvar i = 0; i < 3; i++) begin : g_db
    calc_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset_n(reset_n), .raw(btn[i]), .pulse(ev[i])
    );
  end
  assign ev_adv  = ev[0];
  assign ev_load = ev[1];
  assign ev_exec = ev[2];

  // Quotient and remainder share the divider; sqrt unit takes {operand_b, operand_a}.
  always_comb begin
    owner_mask = 5'b00000;
    sel_result = 8'h00;
    case (op_sel)
      3'd0: begin owner_mask = 5'b00001; sel_result = sum_in;  end
      3'd1: begin owner_mask = 5'b00010; sel_result = diff_in; end
      3'd2: begin owner_mask = 5'b00100; sel_result = quot_in; end
      3'd3: begin owner_mask = 5'b01000; sel_result = prod_in; end
      3'd4: begin owner_mask = 5'b00100; sel_result = rem_in;  end
      3'd5: begin owner_mask = 5'b10000; sel_result = sqrt_in; end
      default: ;
    endcase
  end

  assign owner_done = |(unit_done & owner_mask);
  assign divz       = ((op_sel == 3'd2) || (op_sel == 3'd4)) && (operand_b == 4'd0);
  assign busy       = (state != IDLE);

`ifdef CALC_TIMEOUT_EN
  logic [7:0] wait_cnt;
  assign timed_out = (state == WAIT) && !owner_done && (wait_cnt == TIMEOUT_CYCLES - 8'd1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            wait_cnt <= '0;
    else if (state == ISSUE) wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign timed_out   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // LATCH occupies the cycle in which the owning done is seen, so the result lands one edge later.
  always_comb begin
    phase      = state;
    if (state == WAIT && owner_done) phase = LATCH;
    state_nx   = state;
    unit_start = 5'b00000;
    case (phase)
      IDLE:  if (ev_exec) state_nx = ISSUE;
      ISSUE: begin
        if (divz) state_nx = IDLE;
        else begin
          unit_start = owner_mask;
          state_nx   = WAIT;
        end
      end
      WAIT:  if (timed_out) state_nx = IDLE;
      LATCH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_sel       <= '0;
      operand_a    <= '0;
      operand_b    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err_divzero  <= 1'b0;
`ifdef CALC_TIMEOUT_EN
      err_timeout  <= 1'b0;
`endif
    end else begin
      case (phase)
        IDLE: begin
          if (ev_load) begin
            operand_a <= sw[3:0];
            operand_b <= sw[7:4];
          end
          if (ev_adv) op_sel <= (op_sel == 3'd5) ? 3'd0 : op_sel + 3'd1;
          if (ev_exec) begin
            result_valid <= 1'b0;
            err_divzero  <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            err_timeout  <= 1'b0;
`endif
          end
        end
        ISSUE: if (divz) begin
          result       <= 8'hFF;
          err_divzero  <= 1'b1;
          result_valid <= 1'b1;
        end
`ifdef CALC_TIMEOUT_EN
        WAIT: if (timed_out) begin
          result       <= 8'hEE;
          err_timeout  <= 1'b1;
          result_valid <= 1'b1;
        end
`endif
        LATCH: begin
          result       <= sel_result;
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with a short debounce; timeout case built with CALC_TIMEOUT_EN.

module tb_calc_op_sequencer;
  localparam logic [15:0] DB = 16'd4;
  localparam logic [7:0]  TO = 8'd10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] sw;
  logic [2:0] btn;
  logic [2:0] op_sel;
  logic [3:0] operand_a, operand_b;
  logic [4:0] unit_start, unit_done;
  logic [7:0] sum_in, diff_in, quot_in, rem_in, prod_in, sqrt_in, result;
  logic       result_valid, busy, err_divzero, err_timeout;

  always #5 clk = ~clk;

  calc_op_sequencer #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw), .btn(btn), .op_sel(op_sel),
    .operand_a(operand_a), .operand_b(operand_b), .unit_start(unit_start),
    .unit_done(unit_done), .sum_in(sum_in), .diff_in(diff_in), .quot_in(quot_in),
    .rem_in(rem_in), .prod_in(prod_in), .sqrt_in(sqrt_in), .result(result),
    .result_valid(result_valid), .busy(busy), .err_divzero(err_divzero),
    .err_timeout(err_timeout)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [4:0] start_h [64];
  logic       busy_h  [64];
  logic       vld_h   [64];
  int n_start, n_busy;
  logic [2:0] exp_seq [6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1; tick(8);
    btn[b] = 1'b0; tick(8);
  endtask

  task automatic release_all();
    btn = '0; unit_done = '0; tick(8);
  endtask

  // Cycle 0 is the execute press; with an idle debouncer the event is in cycle 6, ISSUE in 7.
  task automatic run_exec(input logic [4:0] mask, input logic [4:0] noise,
                          input int done_cyc, input int ncyc, input bit repress);
    btn[2] = 1'b1;
    n_start = 0; n_busy = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (repress && c == 8)  btn[2] = 1'b0;
      if (repress && c == 16) btn[2] = 1'b1;
      unit_done = noise | ((done_cyc >= 0 && c >= done_cyc) ? mask : 5'b00000);
      start_h[c] = unit_start;
      busy_h[c]  = busy;
      vld_h[c]   = result_valid;
      if (unit_start != 5'b00000) n_start++;
      if (busy) n_busy++;
      tick();
    end
  endtask

  initial begin
    exp_seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    reset_n = 1'b0; btn = 3'b001; sw = '0; unit_done = '0;
    sum_in = 8'h08; diff_in = 8'h11; quot_in = 8'h01; rem_in = 8'h02;
    prod_in = 8'h15; sqrt_in = 8'h0C;
    tick(3);
    chk("rst_op", op_sel, 0);
    chk("rst_opnd", {operand_a, operand_b}, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {result_valid, busy, err_divzero, err_timeout, unit_start}, 0);
    reset_n = 1'b1;
    tick(20);
    chk("held_btn_no_event", op_sel, 0);
    release_all();

    // add: A=5 B=3, done tied high
    sw = 8'h35; press(1);
    chk("load_a", operand_a, 4'h5);
    chk("load_b", operand_b, 4'h3);
    run_exec(5'b00001, 5'b00000, 0, 12, 0);
    chk("add_start", start_h[7], 5'b00001);
    chk("add_nstart", n_start, 1);
    chk("add_busy_rise", {busy_h[6], busy_h[7]}, 2'b01);
    chk("add_busy_cnt", n_busy, 2);
    chk("add_vld_t3", {vld_h[8], vld_h[9]}, 2'b01);
    chk("add_result", result, 8'h08);
    release_all();

    // advance sequence with press-to-event latency check on the first
    btn[0] = 1'b1; tick(6);
    chk("adv_lat_early", op_sel, 0);
    tick(1);
    chk("adv_1", op_sel, 1);
    tick(1); btn[0] = 1'b0; tick(8);
    for (int i = 0; i < 6; i++) begin
      press(0);
      chk($sformatf("adv_%0d", i + 2), op_sel, exp_seq[i]);
    end
    btn[0] = 1'b1; tick(3); btn[0] = 1'b0; tick(12);
    chk("glitch_no_adv", op_sel, 1);

    // quotient with B=0
    press(0);
    chk("op_quot", op_sel, 2);
    sw = 8'h07; press(1);
    run_exec(5'b00100, 5'b00000, 0, 12, 0);
    chk("dz_nstart", n_start, 0);
    chk("dz_vld", {vld_h[7], vld_h[8]}, 2'b01);
    chk("dz_busy_cnt", n_busy, 1);
    chk("dz_result", result, 8'hFF);
    chk("dz_flag", err_divzero, 1);
    release_all();
    sw = 8'h57; press(1);
    run_exec(5'b00100, 5'b00000, 0, 12, 0);
    chk("quot_start", start_h[7], 5'b00100);
    chk("quot_result", result, 8'h01);
    chk("dz_cleared", err_divzero, 0);
    release_all();

    // multiply, done 5 cycles after start, foreign done ignored
    press(0);
    sw = 8'h37; press(1);
    chk("mul_opnd", {op_sel, operand_a, operand_b}, {3'd3, 4'h7, 4'h3});
    run_exec(5'b01000, 5'b00001, 12, 16, 0);
    chk("mul_start", start_h[7], 5'b01000);
    chk("mul_nstart", n_start, 1);
    chk("mul_vld", {vld_h[12], vld_h[13]}, 2'b01);
    chk("mul_result", result, 8'h15);
    release_all();
    prod_in = 8'h2A;
    run_exec(5'b01000, 5'b00000, 30, 42, 1);
    chk("midwait_nstart", n_start, 1);
    chk("midwait_busy_cnt", n_busy, 24);
    chk("midwait_vld", vld_h[31], 1);
    chk("midwait_result", result, 8'h2A);
    release_all();

    // sqrt, done never arrives
    press(0); press(0);
    chk("op_sqrt", op_sel, 5);
`ifdef CALC_TIMEOUT_EN
    run_exec(5'b10000, 5'b00000, -1, 24, 0);
    chk("to_start", start_h[7], 5'b10000);
    chk("to_vld", {vld_h[17], vld_h[18]}, 2'b01);
    chk("to_busy_cnt", n_busy, 11);
    chk("to_result", result, 8'hEE);
    chk("to_flag", err_timeout, 1);
    release_all();
    run_exec(5'b10000, 5'b00000, -1, 10, 0);
`else
    run_exec(5'b10000, 5'b00000, -1, 24, 0);
    chk("sqrt_start", start_h[7], 5'b10000);
    chk("wait_holds", {busy_h[23], vld_h[23], err_timeout}, 3'b100);
`endif
    chk("pre_rst_busy", busy, 1);
    reset_n = 1'b0; #1;
    chk("midrst_outs", {op_sel, operand_a, operand_b, unit_start, result}, 0);
    chk("midrst_flags", {result_valid, busy, err_divzero, err_timeout}, 0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    unit_done = 5'b11111; tick(3); unit_done = 5'b00000; tick(2);
    chk("post_rst_result", {result, result_valid}, 0);
    chk("post_rst_busy", busy, 0);
    release_all();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Controller for the calculator's arithmetic units. It debounces the three push-buttons, holds the operand registers and the selected operation, and sequences one operation at a time: it issues a start pulse to the owning unit, waits for that unit's done, then latches the 8-bit result for the BCD/seven-segment path and the LEDs. The adder, subtractor, divider, multiplier and square-root units sit behind it as the shared datapath; the divider serves both quotient and remainder.

## Interface
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles required after synchronisation before a button level is accepted
- TIMEOUT_CYCLES, 8'd255, maximum WAIT cycles before abort (only with CALC_TIMEOUT_EN)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sw  in  8  operand switches: A=sw[3:0], B=sw[7:4]
- btn  in  3  raw buttons: [0] advance op, [1] load operands, [2] execute
- op_sel  out  3  current op: 0 add, 1 sub, 2 quotient, 3 mul, 4 remainder, 5 sqrt
- operand_a, operand_b  out  4 each  registered operands to all units
- unit_start  out  5  one-cycle start pulses: [0] add, [1] sub, [2] div, [3] mul, [4] sqrt
- unit_done  in  5  per-unit done, level or pulse, sampled only in WAIT
- sum_in, diff_in, quot_in, rem_in, prod_in, sqrt_in  in  8 each  unit results
- result  out  8  latched result, drives LEDs and BCD converter
- result_valid  out  1  result holds a completed operation
- busy  out  1  high in ISSUE, WAIT and LATCH
- err_divzero, err_timeout  out  1 each  sticky error flags

## Operation
- Per button: 2-flop synchroniser, then a counter. A new level is accepted after DEBOUNCE_CYCLES consecutive cycles at that level. A one-cycle event fires on each accepted 0->1 transition.
- FSM states: IDLE, ISSUE, WAIT, LATCH.
- IDLE, load event: operand_a<=sw[3:0], operand_b<=sw[7:4].
- IDLE, advance event: op_sel increments and wraps 5->0.
- IDLE, execute event: go to ISSUE; clear result_valid, err_divzero, err_timeout.
- Load, advance and execute events in the same cycle are all applied. ISSUE uses the registered (updated) operands and op.
- Events arriving outside IDLE are discarded, not queued.
- ISSUE, op 2 or 4 with operand_b==0: no start pulse; result<=8'hFF; err_divzero<=1; result_valid<=1; return to IDLE.
- ISSUE, otherwise: pulse unit_start for the owning unit (ops 2 and 4 both use bit 2); go to WAIT.
- Sqrt radicand is {operand_b, operand_a}.
- WAIT: when unit_done of the owning unit is high, go to LATCH. The done of any other unit is ignored.
- LATCH: result<=selected *_in (op 2 -> quot_in, op 4 -> rem_in); result_valid<=1; go to IDLE.
- Reset, including mid-operation: every output goes to 0, FSM to IDLE, debounced levels to 0. No event is generated by a button already held during reset until it is released and pressed again.

## Timing
- Execute event at cycle t: ISSUE at t+1, unit_start high only in t+1, WAIT from t+2.
- Done first seen high at cycle d: LATCH at d; result and result_valid update at d+1.
- A unit with done tied high completes with result valid at t+3.
- Divide-by-zero: result=8'hFF and flag at t+2.
- busy asserts at t+1 and deasserts in the same cycle result_valid rises.
- Button press-to-event latency: 2 + DEBOUNCE_CYCLES cycles.

## Configuration
- CALC_TIMEOUT_EN defined:
  - 8-bit WAIT counter, cleared on entering WAIT.
  - If no done after TIMEOUT_CYCLES cycles in WAIT: result<=8'hEE, err_timeout<=1, result_valid<=1, return to IDLE.
- CALC_TIMEOUT_EN undefined:
  - WAIT holds indefinitely; err_timeout is constant 0; no counter is synthesised.

## Test plan
- Load sw=8'h35, op 0, execute, done tied high, sum_in=8'h08 -> result=8'h08, result_valid=1 at t+3, busy high exactly 2 cycles.
- Advance 7 times from reset -> op_sel sequence 1,2,3,4,5,0,1. A bounce glitch shorter than DEBOUNCE_CYCLES (bench value 4) produces no advance.
- op 3, A=4'h7, B=4'h3, done asserted 5 cycles after start, prod_in=8'h15 -> single start pulse on bit 3, result=8'h15; execute pressed mid-WAIT is ignored.
- op 2, B=0, execute -> no unit_start, result=8'hFF, err_divzero=1. A following valid execute clears err_divzero.
- With CALC_TIMEOUT_EN and TIMEOUT_CYCLES=10, op 5, done never asserted -> result=8'hEE, err_timeout=1 after 10 WAIT cycles.
- reset_n low during WAIT -> all outputs 0 immediately; a later done pulse produces no result update.
